simon_round_engine: RTL and testbench

- Iterative SIMON-family Feistel cipher core, parametrised in word width and round count.
- Encrypts or decrypts one 2×WORD_W block per transaction.
- Sits between the data-path buffer and the round-key store:
  - pulls one round key per cycle via an index/valid handshake;
  - returns the result on a valid/ready output.
- Replaces fixed 16-bit, free-running round logic with a handshaked, stall-aware, width-generic engine.

---
 rtl/simon_round_engine_pkg.sv | 20 ++
 rtl/simon_round_engine_if.sv | 37 +++
 rtl/simon_round_engine_round_f.sv | 25 ++
 rtl/simon_round_engine.sv | 116 +++++++++++
 tb/tb_simon_round_engine.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_round_engine_pkg.sv
// Shared types and constants for the SIMON round engine: FSM states, cipher
// direction and the three rotation amounts of the round function.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  localparam int ROT_A = 1;
  localparam int ROT_B = 8;
  localparam int ROT_C = 2;

endpackage

// File: rtl/simon_round_engine_if.sv
// Block/key/result handshake bundle of the SIMON round engine. The engine
// side uses the slave modport; dbg_state exposes the FSM for observation.
interface simon_round_engine_if #(
  parameter int WORD_W = 16,
  parameter int ROUNDS = 32
);
  import simon_pkg::*;

  localparam int IDX_W = $clog2(ROUNDS);

  // valid/ready: a transfer happens on a rising clk edge where both valid and
  // ready are high; the source holds its payload stable until that edge.
  // rk_valid qualifies rk for the rk_idx currently driven by the engine.
  logic                  in_valid;
  logic                  in_ready;
  logic                  mode;
  logic [2*WORD_W-1:0]   data_in;
  logic [IDX_W-1:0]      rk_idx;
  logic [WORD_W-1:0]     rk;
  logic                  rk_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WORD_W-1:0]   data_out;
  logic                  busy;
  state_e                dbg_state;

  modport slave (
    input  in_valid, mode, data_in, rk, rk_valid, out_ready,
    output in_ready, rk_idx, out_valid, data_out, busy, dbg_state
  );

  modport master (
    output in_valid, mode, data_in, rk, rk_valid, out_ready,
    input  in_ready, rk_idx, out_valid, data_out, busy, dbg_state
  );

endinterface

// File: rtl/simon_round_engine_round_f.sv
// One SIMON Feistel round: (x, y) -> (y ^ f(x) ^ rk, x) with
// f(x) = (rotl(x,1) & rotl(x,8)) ^ rotl(x,2). Purely combinational.
module simon_round_f
  import simon_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] rk,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next
);

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  logic [WORD_W-1:0] f_x;

  assign f_x    = (rotl(x, ROT_A) & rotl(x, ROT_B)) ^ rotl(x, ROT_C);
  assign x_next = y ^ f_x ^ rk;
  assign y_next = x;

endmodule

// File: rtl/simon_round_engine.sv
// Iterative, stall-aware SIMON encrypt/decrypt engine, one round per key beat.
// Optional SIMON_ABORT_EN adds an abort input that drops the block in flight.
module simon_round_engine
  import simon_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ROUNDS = 32
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SIMON_ABORT_EN
  input  logic abort,
`endif
  simon_round_engine_if.slave bus
);

  localparam int IDX_W = $clog2(ROUNDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [WORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*WORD_W-1:0] dout_q, dout_d;
  logic [WORD_W-1:0]   x_nx, y_nx;
  logic [IDX_W-1:0]    rev_idx;
  logic                abort_w;

`ifdef SIMON_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  simon_round_f #(.WORD_W(WORD_W)) u_round_f (
    .x      (x_q),
    .y      (y_q),
    .rk     (bus.rk),
    .x_next (x_nx),
    .y_next (y_nx)
  );

  assign rev_idx = LAST_IDX - cnt_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ENC;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d  = mode_e'(bus.mode);
          cnt_d   = '0;
          state_d = RUN;
          // Decrypt runs the forward round on swapped halves with reversed keys.
          if (bus.mode) begin
            x_d = bus.data_in[WORD_W-1:0];
            y_d = bus.data_in[2*WORD_W-1:WORD_W];
          end else begin
            x_d = bus.data_in[2*WORD_W-1:WORD_W];
            y_d = bus.data_in[WORD_W-1:0];
          end
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (bus.rk_valid) begin
          x_d   = x_nx;
          y_d   = y_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            dout_d  = (mode_q == DEC) ? {y_nx, x_nx} : {x_nx, y_nx};
          end
        end
      end
      DONE: begin
        if (abort_w || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.data_out  = dout_q;
  assign bus.dbg_state = state_q;
  assign bus.rk_idx    = (state_q != RUN) ? '0 :
                         (mode_q == DEC)  ? rev_idx : cnt_q[IDX_W-1:0];

endmodule

// File: tb/tb_simon_round_engine.sv
// Bench for simon_round_engine: a 16/32 instance for the known-answer, stall,
// backpressure and reset cases, and a 24/36 instance for random round trips.
module tb_simon_round_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tb_sel = 1'b0;
  logic        tb_in_valid = 1'b0;
  logic        tb_mode = 1'b0;
  logic [47:0] tb_din = '0;
  logic        tb_rkv = 1'b1;
  logic        tb_out_ready = 1'b0;
`ifdef SIMON_ABORT_EN
  logic        tb_abort = 1'b0;
`endif

  logic [15:0] rka [0:31];
  logic [23:0] rkb [0:35];

  int n_checks = 0;
  int n_err = 0;

  simon_round_engine_if #(.WORD_W(16), .ROUNDS(32)) a_if ();
  simon_round_engine_if #(.WORD_W(24), .ROUNDS(36)) b_if ();

  simon_round_engine #(.WORD_W(16), .ROUNDS(32)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SIMON_ABORT_EN
    .abort (tb_abort & ~tb_sel),
`endif
    .bus   (a_if)
  );

  simon_round_engine #(.WORD_W(24), .ROUNDS(36)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SIMON_ABORT_EN
    .abort (tb_abort & tb_sel),
`endif
    .bus   (b_if)
  );

  assign a_if.in_valid  = tb_in_valid & ~tb_sel;
  assign b_if.in_valid  = tb_in_valid & tb_sel;
  assign a_if.mode      = tb_mode;
  assign b_if.mode      = tb_mode;
  assign a_if.data_in   = tb_din[31:0];
  assign b_if.data_in   = tb_din;
  assign a_if.rk_valid  = tb_rkv;
  assign b_if.rk_valid  = tb_rkv;
  assign a_if.out_ready = tb_out_ready;
  assign b_if.out_ready = tb_out_ready;
  assign a_if.rk        = rka[a_if.rk_idx];
  assign b_if.rk        = rkb[b_if.rk_idx];

  logic        obs_in_ready, obs_out_valid, obs_busy;
  logic [47:0] obs_dout;
  logic [7:0]  obs_rk_idx;
  assign obs_in_ready  = tb_sel ? b_if.in_ready  : a_if.in_ready;
  assign obs_out_valid = tb_sel ? b_if.out_valid : a_if.out_valid;
  assign obs_busy      = tb_sel ? b_if.busy      : a_if.busy;
  assign obs_dout      = tb_sel ? b_if.data_out  : {16'd0, a_if.data_out};
  assign obs_rk_idx    = tb_sel ? {2'd0, b_if.rk_idx} : {3'd0, a_if.rk_idx};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cur_w();  return tb_sel ? 24 : 16; endfunction
  function automatic int cur_r();  return tb_sel ? 36 : 32; endfunction

  function automatic logic [63:0] key_of(input int i);
    return tb_sel ? 64'(rkb[i]) : 64'(rka[i]);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((v << s) | (v >> (w - s))) & m;
  endfunction

  function automatic logic [63:0] f_of(input logic [63:0] v, input int w);
    return (rotl(v, 1, w) & rotl(v, 8, w)) ^ rotl(v, 2, w);
  endfunction

  function automatic logic [47:0] model_enc(input logic [47:0] blk);
    int w; logic [63:0] m, x, y, t;
    w = cur_w(); m = (64'd1 << w) - 64'd1;
    x = (64'(blk) >> w) & m;
    y = 64'(blk) & m;
    for (int i = 0; i < cur_r(); i++) begin
      t = x;
      x = y ^ f_of(x, w) ^ key_of(i);
      y = t;
    end
    t = (x << w) | y;
    return t[47:0];
  endfunction

  // Direct inverse of the Feistel round, walking the keys backwards.
  function automatic logic [47:0] model_dec(input logic [47:0] blk);
    int w; logic [63:0] m, x, y, px;
    w = cur_w(); m = (64'd1 << w) - 64'd1;
    x = (64'(blk) >> w) & m;
    y = 64'(blk) & m;
    for (int i = cur_r() - 1; i >= 0; i--) begin
      px = y;
      y  = x ^ f_of(y, w) ^ key_of(i);
      x  = px;
    end
    px = (x << w) | y;
    return px[47:0];
  endfunction

  task automatic expand_simon32_64();
    logic [15:0] k [0:31];
    logic [61:0] z0;
    logic [15:0] tmp;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    k[0] = 16'h0100; k[1] = 16'h0908; k[2] = 16'h1110; k[3] = 16'h1918;
    for (int i = 4; i < 32; i++) begin
      tmp  = {k[i-1][2:0], k[i-1][15:3]};
      tmp  = tmp ^ k[i-3];
      tmp  = tmp ^ {tmp[0], tmp[15:1]};
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, z0[61-(i-4)]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) rka[i] = k[i];
  endtask

  // ---------------- driver ----------------
  // Entered and left at a negedge with the selected engine idle.
  task automatic run_block(input logic md, input logic [47:0] din, input int s1, input int s2,
                           input int slen, input int bp, output logic [47:0] dout, output int lat);
    int rnd, st, cyc, r;
    r = cur_r(); rnd = 0; st = 0; cyc = 0;
    check("idle_in_ready", 64'(obs_in_ready), 64'd1);
    tb_in_valid = 1'b1; tb_mode = md; tb_din = din; tb_rkv = 1'b1; tb_out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    tb_mode = ~md;
    while (!obs_out_valid && cyc < 400) begin
      check("rk_idx", 64'(obs_rk_idx), 64'(md ? r - 1 - rnd : rnd));
      check("run_in_ready", 64'(obs_in_ready), 64'd0);
      tb_in_valid = 1'($urandom_range(0, 1));
      tb_din = {16'($urandom), 32'($urandom)};
      if ((rnd == s1 || rnd == s2) && st < slen) begin
        tb_rkv = 1'b0; st++;
      end else begin
        tb_rkv = 1'b1;
      end
      @(posedge clk); cyc++;
      if (tb_rkv) begin rnd++; st = 0; end
      @(negedge clk);
    end
    tb_rkv = 1'b1;
    lat = cyc;
    check("done_busy", 64'(obs_busy), 64'd1);
    check("done_rounds", 64'(rnd), 64'(r));
    dout = obs_dout;
    for (int i = 0; i < bp; i++) begin
      tb_in_valid = 1'($urandom_range(0, 1));
      tb_din = {16'($urandom), 32'($urandom)};
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 64'(obs_out_valid), 64'd1);
      check("bp_data_hold", 64'(obs_dout), 64'(dout));
      check("bp_in_ready", 64'(obs_in_ready), 64'd0);
    end
    tb_out_ready = 1'b1; tb_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_out_ready = 1'b0; tb_in_valid = 1'b0;
    check("hs_out_valid", 64'(obs_out_valid), 64'd0);
    check("hs_in_ready", 64'(obs_in_ready), 64'd1);
    check("hs_not_accepted", 64'(obs_busy), 64'd0);
  endtask

  initial begin
    logic [47:0] d, c, p, m;
    int lat, s1, slen;

    expand_simon32_64();
    for (int i = 0; i < 36; i++) rkb[i] = 24'($urandom);

    repeat (3) @(negedge clk);
    check("rst_a_in_ready", 64'(a_if.in_ready), 64'd1);
    check("rst_a_out_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_a_busy", 64'(a_if.busy), 64'd0);
    check("rst_a_data_out", 64'(a_if.data_out), 64'd0);
    check("rst_a_rk_idx", 64'(a_if.rk_idx), 64'd0);
    check("rst_b_data_out", 64'(b_if.data_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tb_sel = 1'b0;
    run_block(1'b0, 48'h6565_6877, -1, -1, 0, 0, d, lat);
    check("kat_enc", 64'(d), 64'h c69b_e9bb);
    check("kat_enc_model", 64'(model_enc(48'h6565_6877)), 64'h c69b_e9bb);
    check("kat_enc_lat", 64'(lat), 64'd32);

    run_block(1'b1, 48'hc69b_e9bb, -1, -1, 0, 0, d, lat);
    check("kat_dec", 64'(d), 64'h6565_6877);
    check("kat_dec_lat", 64'(lat), 64'd32);

    run_block(1'b0, 48'h6565_6877, 5, 17, 3, 0, d, lat);
    check("stall_enc", 64'(d), 64'h c69b_e9bb);
    check("stall_lat", 64'(lat), 64'd38);

    run_block(1'b0, 48'h6565_6877, -1, -1, 0, 10, d, lat);
    check("bp_enc", 64'(d), 64'h c69b_e9bb);

    // Abandon a block at round 12 with an asynchronous reset between edges.
    tb_in_valid = 1'b1; tb_mode = 1'b0; tb_din = 48'h1234_5678; tb_rkv = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(a_if.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(a_if.out_valid), 64'd0);
    check("mid_rst_busy", 64'(a_if.busy), 64'd0);
    check("mid_rst_data_out", 64'(a_if.data_out), 64'd0);
    check("mid_rst_rk_idx", 64'(a_if.rk_idx), 64'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_block(1'b0, 48'h6565_6877, -1, -1, 0, 0, d, lat);
    check("post_rst_enc", 64'(d), 64'h c69b_e9bb);

    for (int sel = 0; sel < 2; sel++) begin
      tb_sel = sel[0];
      for (int n = 0; n < (sel == 0 ? 10 : 100); n++) begin
        m = 48'((64'd1 << (2 * cur_w())) - 64'd1);
        p = {16'($urandom), 32'($urandom)} & m;
        s1 = $urandom_range(0, cur_r() - 1);
        slen = $urandom_range(0, 2);
        run_block(1'b0, p, s1, -1, slen, $urandom_range(0, 2), c, lat);
        check("rnd_enc", 64'(c), 64'(model_enc(p)));
        check("rnd_enc_lat", 64'(lat), 64'(cur_r() + slen));
        run_block(1'b1, c, -1, -1, 0, 0, d, lat);
        check("rnd_dec_model", 64'(model_dec(c)), 64'(p));
        check("rnd_roundtrip", 64'(d), 64'(p));
      end
    end

`ifdef SIMON_ABORT_EN
    tb_sel = 1'b1;
    d = obs_dout;
    tb_in_valid = 1'b1; tb_mode = 1'b0; tb_din = 48'h0123_4567_89ab; tb_rkv = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_abort = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_abort = 1'b0;
    check("abort_in_ready", 64'(obs_in_ready), 64'd1);
    check("abort_busy", 64'(obs_busy), 64'd0);
    check("abort_data_hold", 64'(obs_dout), 64'(d));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_no_out_valid", 64'(obs_out_valid), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
